// File: rtl/alsu_spi_cmd_rx.sv
// SPI mode-0 slave that turns 16-bit command frames into ALSU controls
// and shifts the previous ALSU result back out on miso.
`timescale 1ns/1ps
module alsu_spi_cmd_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       miso,
  input  logic [5:0] result,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic [2:0] opcode,
  output logic       cin,
  output logic       serial_in,
  output logic       direction,
  output logic       red_op_A,
  output logic       red_op_B,
  output logic       bypass_A,
  output logic       bypass_B,
  output logic       cmd_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(FRAME_BITS + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD, ERR} state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   ss_d;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall;
  logic ss_rise, ss_fall;

  logic [CW-1:0]         cnt;
  logic [FRAME_BITS-1:0] sr;
  logic [5:0]            res_sr;
  logic                  pend;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;

  assign miso = ~ss_s & res_sr[5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      res_sr    <= '0;
      pend      <= 1'b0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      {opcode, A, B, cin, serial_in, direction,
       red_op_A, red_op_B, bypass_A, bypass_B} <= '0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall || pend) begin
            pend   <= 1'b0;
            cnt    <= '0;
            sr     <= '0;
            res_sr <= result;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          // ss_n rise wins over a coincident sclk edge
          if (ss_rise) begin
            state <= (cnt == CW'(FRAME_BITS)) ? LOAD : ERR;
          end else if (sclk_rise) begin
            sr <= {sr[FRAME_BITS-2:0], mosi_s};
            if (cnt != CW'(FRAME_BITS + 1))
              cnt <= cnt + 1'b1;
          end else if (sclk_fall) begin
            res_sr <= {res_sr[4:0], 1'b0};
          end
        end
        LOAD: begin
          {opcode, A, B, cin, serial_in, direction,
           red_op_A, red_op_B, bypass_A, bypass_B} <= sr;
          cmd_valid <= 1'b1;
          if (ss_fall) pend <= 1'b1;
          state <= IDLE;
        end
        ERR: begin
          frame_err <= 1'b1;
          if (ss_fall) pend <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alsu_spi_cmd_rx.sv
// Directed bench for alsu_spi_cmd_rx with an expected-response queue.
`timescale 1ns/1ps
module tb_alsu_spi_cmd_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, ss_n, mosi;
  logic       miso;
  logic [5:0] result;
  logic [2:0] A, B, opcode;
  logic       cin, serial_in, direction;
  logic       red_op_A, red_op_B, bypass_A, bypass_B;
  logic       cmd_valid, frame_err;

  int checks = 0;
  int errors = 0;
  int ncv = 0;
  int nfe = 0;

  typedef struct {
    bit          err;
    logic [15:0] f;
  } exp_t;

  exp_t        q[$];
  logic [15:0] cur;
  logic [15:0] obs;
  logic [31:0] mb;

  alsu_spi_cmd_rx dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n),
    .mosi(mosi), .miso(miso), .result(result),
    .A(A), .B(B), .opcode(opcode), .cin(cin),
    .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B),
    .bypass_A(bypass_A), .bypass_B(bypass_B),
    .cmd_valid(cmd_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  assign obs = {opcode, A, B, cin, serial_in, direction,
                red_op_A, red_op_B, bypass_A, bypass_B};

  always @(posedge clk) begin
    if (cmd_valid) ncv++;
    if (frame_err) nfe++;
  end

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic spi_frame(input logic [31:0] data, input int nbits,
                           output logic [31:0] mbits);
    mbits = '0;
    ss_n = 1'b0;
    #100;
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = data[i];
      #40 sclk = 1'b1;
      mbits[i] = miso;
      #40 sclk = 1'b0;
    end
    #100 ss_n = 1'b1;
    mosi = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    int   n = 0;
    bit   seen = 0;
    exp_t e;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (cmd_valid || frame_err) seen = 1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen && q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_err"}, 32'(frame_err), 32'(e.err));
      chk({tag, "_valid"}, 32'(cmd_valid), 32'(!e.err));
      chk({tag, "_fields"}, 32'(obs), 32'(e.f));
      @(negedge clk);
      chk({tag, "_pulse_end"}, {30'd0, cmd_valid, frame_err}, 32'd0);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] data,
                     input int nbits);
    exp_t e;
    e.err = (nbits != 16);
    if (!e.err) cur = data[15:0];
    e.f = cur;
    q.push_back(e);
    spi_frame(data, nbits, mb);
    wait_resp(tag);
    chk({tag, "_miso"}, mb, 32'(6'b101101) << (nbits - 6));
    chk({tag, "_miso_idle"}, 32'(miso), 32'd0);
    #100;
    chk({tag, "_hold"}, 32'(obs), 32'(cur));
  endtask

  initial begin
    int cv0, fe0;
    rst = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    result = 6'b101101;
    cur = '0;
    #23;
    chk("rst_fields", 32'(obs), 32'd0);
    chk("rst_pulses", {30'd0, cmd_valid, frame_err}, 32'd0);
    chk("rst_miso", 32'(miso), 32'd0);
    rst = 1'b0;
    #50;

    run("bypass_red", 32'h000F, 16);

    // abort a frame with reset after 7 bits
    cv0 = ncv; fe0 = nfe;
    ss_n = 1'b0;
    #100;
    for (int i = 15; i >= 9; i--) begin
      mosi = 1'(16'h55C0 >> i);
      #40 sclk = 1'b1;
      #40 sclk = 1'b0;
    end
    rst = 1'b1;
    #3;
    chk("midrst_fields", 32'(obs), 32'd0);
    chk("midrst_miso", 32'(miso), 32'd0);
    chk("midrst_pulses", {30'd0, cmd_valid, frame_err}, 32'd0);
    #20 ss_n = 1'b1; mosi = 1'b0;
    #20 rst = 1'b0;
    cur = '0;
    #300;
    chk("midrst_no_pulse", 32'((ncv - cv0) + (nfe - fe0)), 32'd0);

    run("add", 32'h55C0, 16);

    // sclk activity with ss_n high must be ignored
    cv0 = ncv; fe0 = nfe;
    for (int i = 0; i < 4; i++) begin
      #40 sclk = 1'b1;
      #40 sclk = 1'b0;
    end
    #200;
    chk("idle_sclk_pulses", 32'((ncv - cv0) + (nfe - fe0)), 32'd0);
    chk("idle_sclk_hold", 32'(obs), 32'h55C0);

    run("short", 32'h7FFF, 15);
    run("long", 32'h3FFFF, 18);
    run("recover", 32'hA5C3, 16);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
